// File: rtl/tile_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tile_drain                                                     |
// | Brief   : Captures one MAT_R-element result vector and streams it out    |
// |           one requantized (shift + saturate) element per beat.           |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tile_drain #(
  parameter int MAT_R       = 4,
  parameter int OUT_BITS    = 4,
  parameter int STREAM_BITS = 4,
  parameter int SHIFT       = 0,
  parameter int CNT_BITS    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [MAT_R*OUT_BITS-1:0] res_vec,
  output logic                      s_valid,
  input  logic                      s_ready,
  output logic [STREAM_BITS-1:0]    s_data,
  output logic [$clog2(MAT_R)-1:0]  s_index,
  output logic                      s_last,
  output logic [CNT_BITS-1:0]       vec_count
);

  localparam int c_idx_w = $clog2(MAT_R);
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(MAT_R - 1);

  // Saturation bounds of the stream width, sign-extended to the input width.
  localparam logic signed [OUT_BITS-1:0] c_smax =
    {{(OUT_BITS-STREAM_BITS+1){1'b0}}, {(STREAM_BITS-1){1'b1}}};
  localparam logic signed [OUT_BITS-1:0] c_smin =
    {{(OUT_BITS-STREAM_BITS+1){1'b1}}, {(STREAM_BITS-1){1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [c_idx_w-1:0]         r_idx;
  logic [OUT_BITS-1:0]        r_buf [MAT_R];
  logic [OUT_BITS-1:0]        w_in  [MAT_R];
  logic [CNT_BITS-1:0]        r_cnt;
  logic                       w_load;
  logic                       w_adv;
  logic                       w_done;
  logic                       w_is_last;
  logic signed [OUT_BITS-1:0] w_elem;
  logic signed [OUT_BITS-1:0] w_shr;
  logic [STREAM_BITS-1:0]     w_sat;

  generate
    for (genvar gi = 0; gi < MAT_R; gi++) begin : g_unpack
      assign w_in[gi] = res_vec[gi*OUT_BITS +: OUT_BITS];
    end
  endgenerate

  assign w_is_last = (r_idx == c_last_idx);
  assign w_elem    = r_buf[r_idx];
  assign w_shr     = w_elem >>> SHIFT;
  assign vec_count = r_cnt;

  always_comb begin
    if (w_shr > c_smax) begin
      w_sat = c_smax[STREAM_BITS-1:0];
    end else if (w_shr < c_smin) begin
      w_sat = c_smin[STREAM_BITS-1:0];
    end else begin
      w_sat = w_shr[STREAM_BITS-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    res_ready   = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_index     = '0;
    s_last      = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Gated so the handshake stays closed while reset is asserted.
        res_ready = reset;
        if (res_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_STREAM;
        end
      end
      ST_STREAM: begin
        s_valid   = 1'b1;
        s_index   = r_idx;
        s_data    = w_sat;
        s_last    = w_is_last;
        res_ready = w_is_last & s_ready;
        if (s_ready) begin
          if (w_is_last) begin
            w_done = 1'b1;
            if (res_valid) begin
              w_load = 1'b1;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
      r_cnt <= '0;
      for (int i = 0; i < MAT_R; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      if (w_load) begin
        for (int i = 0; i < MAT_R; i++) begin
          r_buf[i] <= w_in[i];
        end
      end
      if (w_load || w_done) begin
        r_idx <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_done) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_tile_drain                                                  |
// | Brief   : Directed self-checking bench for tile_drain.                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_tile_drain;

  logic        clock;
  logic        reset;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_vec;
  logic        s_valid;
  logic        s_ready;
  logic [3:0]  s_data;
  logic [1:0]  s_index;
  logic        s_last;
  logic [7:0]  vec_count;

  int checks = 0;
  int errors = 0;

  tile_drain #(
    .MAT_R      (4),
    .OUT_BITS   (8),
    .STREAM_BITS(4),
    .SHIFT      (1),
    .CNT_BITS   (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_vec  (res_vec),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_index  (s_index),
    .s_last   (s_last),
    .vec_count(vec_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] pack(input int r0, input int r1, input int r2, input int r3);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(r0);
    b1 = 8'(r1);
    b2 = 8'(r2);
    b3 = 8'(r3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input string tag, input int idx, input int data, input logic last);
    chk({tag, "_valid"}, 32'(s_valid), 1);
    chk({tag, "_index"}, 32'(s_index), idx);
    chk({tag, "_data"}, $signed(s_data), data);
    chk({tag, "_last"}, 32'(s_last), 32'(last));
  endtask

  initial begin
    reset     = 1'b0;
    res_valid = 1'b0;
    s_ready   = 1'b0;
    res_vec   = '0;

    // 1: reset held low 3 cycles
    #1;
    chk("rst_svalid", 32'(s_valid), 0);
    chk("rst_rready", 32'(res_ready), 0);
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("post_rst_svalid", 32'(s_valid), 0);
    chk("post_rst_rready", 32'(res_ready), 1);
    chk("post_rst_cnt", 32'(vec_count), 0);
    chk("post_rst_index", 32'(s_index), 0);

    // 2: plain vector with saturation
    res_vec   = pack(10, -3, 20, -40);
    res_valid = 1'b1;
    s_ready   = 1'b1;
    tick();
    res_valid = 1'b0;
    beat("v1b0", 0, 5, 1'b0);
    chk("v1b0_rready", 32'(res_ready), 0);
    tick(); beat("v1b1", 1, -2, 1'b0);
    tick(); beat("v1b2", 2, 7, 1'b0);
    tick(); beat("v1b3", 3, -8, 1'b1);
    chk("v1b3_rready", 32'(res_ready), 1);
    chk("v1b3_cnt", 32'(vec_count), 0);
    tick();
    chk("v1_idle_svalid", 32'(s_valid), 0);
    chk("v1_idle_rready", 32'(res_ready), 1);
    chk("v1_cnt", 32'(vec_count), 1);

    // 3: backpressure at idx1
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    beat("v2b0", 0, 5, 1'b0);
    tick();
    beat("v2b1", 1, -2, 1'b0);
    s_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      beat("v2hold", 1, -2, 1'b0);
      chk("v2hold_rready", 32'(res_ready), 0);
    end
    s_ready = 1'b1;
    tick(); beat("v2b2", 2, 7, 1'b0);
    tick(); beat("v2b3", 3, -8, 1'b1);

    // 4: next vector accepted during the last beat, no bubble
    res_vec   = pack(2, 4, 6, 8);
    res_valid = 1'b1;
    #1;
    chk("v3_accept_rready", 32'(res_ready), 1);
    tick();
    res_valid = 1'b0;
    beat("v3b0", 0, 1, 1'b0);
    chk("v3b0_cnt", 32'(vec_count), 2);
    tick(); beat("v3b1", 1, 2, 1'b0);
    tick(); beat("v3b2", 2, 3, 1'b0);
    tick(); beat("v3b3", 3, 4, 1'b1);
    tick();
    chk("v3_idle_svalid", 32'(s_valid), 0);
    chk("v3_cnt", 32'(vec_count), 3);

    // 5: reset pulse mid-stream at idx2
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
    tick();
    beat("v4b2", 2, 3, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_svalid", 32'(s_valid), 0);
    chk("midrst_rready", 32'(res_ready), 0);
    chk("midrst_cnt", 32'(vec_count), 0);
    chk("midrst_index", 32'(s_index), 0);
    chk("midrst_data", $signed(s_data), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("midrst_rel_svalid", 32'(s_valid), 0);
    chk("midrst_rel_rready", 32'(res_ready), 1);
    res_vec   = pack(10, -3, 20, -40);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    beat("v5b0", 0, 5, 1'b0);
    tick(); tick(); tick();
    beat("v5b3", 3, -8, 1'b1);
    tick();
    chk("v5_cnt", 32'(vec_count), 1);

    // 6: run the counter up to the wrap point
    res_vec   = pack(2, 4, 6, 8);
    res_valid = 1'b1;
    for (int i = 0; i < 2000 && vec_count != 8'd254; i++) begin
      tick();
    end
    chk("reach_254", 32'(vec_count), 254);
    // Vector 255 streams while a different vector is offered; it must not be taken.
    res_vec = pack(100, 100, 100, 100);
    beat("w0", 0, 1, 1'b0);
    chk("w0_rready", 32'(res_ready), 0);
    tick(); beat("w1", 1, 2, 1'b0);
    chk("w1_rready", 32'(res_ready), 0);
    tick(); beat("w2", 2, 3, 1'b0);
    chk("w2_rready", 32'(res_ready), 0);
    tick(); beat("w3", 3, 4, 1'b1);
    res_valid = 1'b0;
    tick();
    chk("cnt_255", 32'(vec_count), 255);
    chk("idle_255_svalid", 32'(s_valid), 0);
    res_vec   = pack(-128, 127, -1, 0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    beat("x0", 0, -8, 1'b0);
    tick(); beat("x1", 1, 7, 1'b0);
    tick(); beat("x2", 2, -1, 1'b0);
    tick(); beat("x3", 3, 0, 1'b1);
    tick();
    chk("cnt_wrap", 32'(vec_count), 0);
    chk("wrap_idle_svalid", 32'(s_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
